// File: rtl/cfg_bus_pkg.sv
// Shared definitions for the fabric configuration bus: widths, reserved
// addresses and the loader state encoding. pe_tile decode imports this too.
package cfg_bus_pkg;
    localparam int CFG_ADDR_W  = 32;
    localparam int CFG_DATA_W  = 32;
    localparam int FRAME_BYTES = 8;

    localparam logic [CFG_ADDR_W-1:0] IDLE_ADDR = 32'h0000_0000;
    localparam logic [CFG_ADDR_W-1:0] END_ADDR  = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        RECV  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } loader_state_t;
endpackage

// File: rtl/config_stream_loader_if.sv
// Host byte stream handshake plus the broadcast configuration bus.
// The master side is the byte source; the slave side is the loader.
interface config_stream_loader_if;
    import cfg_bus_pkg::*;

    logic [7:0]            byte_in;
    logic                  byte_valid;
    logic                  byte_ready;
    logic [CFG_ADDR_W-1:0] config_addr;
    logic [CFG_DATA_W-1:0] config_data;

    modport master (
        output byte_in, byte_valid,
        input  byte_ready, config_addr, config_data
    );

    modport slave (
        input  byte_in, byte_valid,
        output byte_ready, config_addr, config_data
    );
endinterface

// File: rtl/cfg_frame_assembler.sv
// Collects accepted bytes into a little-endian 64-bit (addr,data) frame and
// flags the cycle in which the eighth byte arrives.
module cfg_frame_assembler
    import cfg_bus_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            byte_in,
    input  logic                  take,
    output logic                  frame_valid,
    output logic [CFG_ADDR_W-1:0] frame_addr,
    output logic [CFG_DATA_W-1:0] frame_data
);
    logic [2:0]  idx;
    logic [63:0] shreg;
    logic [63:0] next_frame;

    // Shifting in from the top leaves byte 0 in bits [7:0] after eight bytes.
    assign next_frame  = {byte_in, shreg[63:8]};
    assign frame_valid = take && (idx == 3'd7);
    assign frame_addr  = next_frame[CFG_ADDR_W-1:0];
    assign frame_data  = next_frame[63:CFG_ADDR_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            idx <= 3'd0;
        end else if (take) begin
            idx <= idx + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (take) begin
            shreg <= next_frame;
        end
    end
endmodule

// File: rtl/config_stream_loader.sv
// Configuration bus initiator: turns the host byte stream into held
// (addr,data) writes separated by an idle cycle, and stops at the END frame.
module config_stream_loader #(
    parameter int                                    HOLD_CYCLES = 1,
    parameter logic [cfg_bus_pkg::CFG_ADDR_W-1:0]    IDLE_ADDR   = cfg_bus_pkg::IDLE_ADDR,
    parameter logic [cfg_bus_pkg::CFG_ADDR_W-1:0]    END_ADDR    = cfg_bus_pkg::END_ADDR,
    parameter int                                    CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    config_stream_loader_if.slave bus,
    output logic                 config_done,
    output logic [CNT_W-1:0]     frame_count,
    output logic                 frame_err
);
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    cfg_bus_pkg::loader_state_t                state;
    logic [HOLD_W-1:0]                         hold;
    logic                                      ready_q;
    logic [cfg_bus_pkg::CFG_ADDR_W-1:0]        addr_q;
    logic [cfg_bus_pkg::CFG_DATA_W-1:0]        data_q;
    logic                                      take;
    logic                                      frame_valid;
    logic [cfg_bus_pkg::CFG_ADDR_W-1:0]        frame_addr;
    logic [cfg_bus_pkg::CFG_DATA_W-1:0]        frame_data;

    assign take            = bus.byte_valid && ready_q;
    assign bus.byte_ready  = ready_q;
    assign bus.config_addr = addr_q;
    assign bus.config_data = data_q;

    cfg_frame_assembler u_asm (
        .clk         (clk),
        .reset       (reset),
        .byte_in     (bus.byte_in),
        .take        (take),
        .frame_valid (frame_valid),
        .frame_addr  (frame_addr),
        .frame_data  (frame_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= cfg_bus_pkg::RECV;
            hold        <= '0;
            ready_q     <= 1'b1;
            addr_q      <= IDLE_ADDR;
            data_q      <= '0;
            config_done <= 1'b0;
            frame_count <= '0;
            frame_err   <= 1'b0;
        end else begin
            unique case (state)
                cfg_bus_pkg::RECV: begin
                    if (frame_valid) begin
                        if (frame_addr == END_ADDR) begin
                            state       <= cfg_bus_pkg::DONE;
                            ready_q     <= 1'b0;
                            config_done <= 1'b1;
                        end else if (frame_addr == IDLE_ADDR) begin
                            // Driving IDLE_ADDR would be invisible to tiles; drop and flag it.
                            frame_err <= 1'b1;
                        end else begin
                            state   <= cfg_bus_pkg::DRIVE;
                            ready_q <= 1'b0;
                            addr_q  <= frame_addr;
                            data_q  <= frame_data;
                            hold    <= '0;
                            if (frame_count != '1) begin
                                frame_count <= frame_count + 1'b1;
                            end
                        end
                    end
                end
                cfg_bus_pkg::DRIVE: begin
                    if (hold == HOLD_LAST) begin
                        state  <= cfg_bus_pkg::GAP;
                        addr_q <= IDLE_ADDR;
                    end else begin
                        hold <= hold + 1'b1;
                    end
                end
                cfg_bus_pkg::GAP: begin
                    state   <= cfg_bus_pkg::RECV;
                    ready_q <= 1'b1;
                end
                cfg_bus_pkg::DONE: begin
                    ready_q <= 1'b0;
                    addr_q  <= IDLE_ADDR;
                end
                default: state <= cfg_bus_pkg::RECV;
            endcase
        end
    end
endmodule

// File: tb/tb_config_stream_loader.sv
// Randomized bench for config_stream_loader: two instances (HOLD 1 / HOLD 3
// with a narrow counter), one exercised at a time against a timeline model.
module tb_config_stream_loader;
    import cfg_bus_pkg::*;

    localparam int H0  = 1;
    localparam int H1  = 3;
    localparam int CW0 = 16;
    localparam int CW1 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int   cur = 0;
    logic rst_req = 1'b1;
    logic b_valid = 1'b0;
    logic [7:0] b_in = 8'h00;
    int   vprob = 100;

    logic rst0, rst1, done0, done1, err0, err1;
    logic [CW0-1:0] cnt0;
    logic [CW1-1:0] cnt1;

    config_stream_loader_if if0();
    config_stream_loader_if if1();

    assign rst0 = rst_req || (cur != 0);
    assign rst1 = rst_req || (cur != 1);
    assign if0.byte_in    = b_in;
    assign if1.byte_in    = b_in;
    assign if0.byte_valid = b_valid && (cur == 0);
    assign if1.byte_valid = b_valid && (cur == 1);

    config_stream_loader #(.HOLD_CYCLES(H0), .CNT_W(CW0)) dut0 (
        .clk(clk), .reset(rst0), .bus(if0.slave),
        .config_done(done0), .frame_count(cnt0), .frame_err(err0)
    );

    config_stream_loader #(.HOLD_CYCLES(H1), .CNT_W(CW1)) dut1 (
        .clk(clk), .reset(rst1), .bus(if1.slave),
        .config_done(done1), .frame_count(cnt1), .frame_err(err1)
    );

    logic        o_ready, o_done, o_err;
    logic [31:0] o_addr, o_data, o_cnt;

    always_comb begin
        o_ready = if0.byte_ready;
        o_addr  = if0.config_addr;
        o_data  = if0.config_data;
        o_done  = done0;
        o_err   = err0;
        o_cnt   = 32'(cnt0);
        if (cur == 1) begin
            o_ready = if1.byte_ready;
            o_addr  = if1.config_addr;
            o_data  = if1.config_data;
            o_done  = done1;
            o_err   = err1;
            o_cnt   = 32'(cnt1);
        end
    end

    // Reference model: m_busy counts the cycles until the loader listens again;
    // the top H of them show the frame, the last one shows the idle gap.
    int          hold_n = H0;
    int          cnt_max = (1 << CW0) - 1;
    int          m_busy, m_cnt, m_n;
    logic        m_done, m_err;
    logic [31:0] m_fa, m_fd;
    logic [7:0]  m_part [8];
    logic [7:0]  src [$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_cnt = 0; m_n = 0; m_done = 1'b0; m_err = 1'b0;
    endtask

    task automatic step();
        logic        acc;
        logic [31:0] a, d;
        logic [31:0] exp_addr;
        @(posedge clk);
        #1;
        if (rst_req) begin
            model_reset();
        end else begin
            acc = b_valid && !m_done && (m_busy == 0);
            if (m_busy > 0) m_busy--;
            if (acc) begin
                void'(src.pop_front());
                m_part[m_n] = b_in;
                m_n++;
                if (m_n == 8) begin
                    m_n = 0;
                    a = {m_part[3], m_part[2], m_part[1], m_part[0]};
                    d = {m_part[7], m_part[6], m_part[5], m_part[4]};
                    if (a == END_ADDR) m_done = 1'b1;
                    else if (a == IDLE_ADDR) m_err = 1'b1;
                    else begin
                        m_busy = hold_n + 1;
                        m_fa = a;
                        m_fd = d;
                        if (m_cnt < cnt_max) m_cnt++;
                    end
                end
            end
        end
        exp_addr = (m_busy >= 2) ? m_fa : IDLE_ADDR;
        chk("byte_ready", o_ready, !m_done && (m_busy == 0));
        chk("config_addr", o_addr, exp_addr);
        if (exp_addr != IDLE_ADDR) chk("config_data", o_data, m_fd);
        chk("config_done", o_done, m_done);
        chk("frame_err", o_err, m_err);
        chk("frame_count", o_cnt, m_cnt);
        b_valid = (src.size() > 0) && ($urandom_range(99) < vprob);
        b_in    = b_valid ? src[0] : 8'($urandom);
    endtask

    task automatic do_reset();
        src.delete();
        b_valid = 1'b0;
        rst_req = 1'b1;
        step();
        chk("reset_data", o_data, 32'h0);
        rst_req = 1'b0;
    endtask

    task automatic push_frame(input logic [31:0] a, input logic [31:0] d);
        for (int i = 0; i < 4; i++) src.push_back(a[8*i +: 8]);
        for (int i = 0; i < 4; i++) src.push_back(d[8*i +: 8]);
        if (!b_valid && src.size() > 0 && $urandom_range(99) < vprob) begin
            b_valid = 1'b1;
            b_in    = src[0];
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((src.size() > 0 || m_busy > 0) && n < budget) begin
            step();
            n++;
        end
        chk("drain_left", src.size(), 0);
        step();
        step();
    endtask

    initial begin
        logic [31:0] a;
        int n;
        model_reset();
        // Instance 0: HOLD_CYCLES = 1
        cur = 0; hold_n = H0; cnt_max = (1 << CW0) - 1;
        do_reset();
        push_frame(32'h0000_0001, 32'hDEAD_BEEF);
        drain(100);
        push_frame(32'h0000_0000, 32'h1234_5678);
        push_frame(32'h0000_0040, 32'hCAFE_0001);
        drain(100);

        // Reset in the middle of a frame discards the partial bytes.
        push_frame(32'h0000_0055, 32'hAAAA_5555);
        n = 0;
        while (m_n < 5 && n < 50) begin step(); n++; end
        chk("partial_bytes", m_n, 5);
        do_reset();
        push_frame(32'h0000_0077, 32'h0BAD_F00D);
        drain(100);

        // Random valid pacing, with occasional dropped IDLE frames.
        vprob = 50;
        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            if (a == END_ADDR || $urandom_range(7) == 0) a = IDLE_ADDR;
            push_frame(a, $urandom);
        end
        drain(2000);

        // END frame stops the loader; later bytes stay unaccepted.
        vprob = 100;
        push_frame(END_ADDR, 32'h1122_3344);
        push_frame(32'h0000_0007, 32'h0000_0008);
        for (int i = 0; i < 40; i++) step();
        chk("bytes_ignored", src.size(), 8);
        src.delete();
        step();

        // Instance 1: HOLD_CYCLES = 3, 2-bit counter saturation.
        cur = 1; hold_n = H1; cnt_max = (1 << CW1) - 1;
        do_reset();
        push_frame(32'h0000_0003, 32'h0000_0005);
        push_frame(32'h0000_0003, 32'h0000_0006);
        drain(100);
        vprob = 60;
        for (int i = 0; i < 4; i++) push_frame(32'h100 + i, $urandom);
        drain(500);
        chk("count_saturated", o_cnt, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
